// File: rtl/pip_ctrl_multi_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Holds the FSM state encoding and the default stall bus width.
package pip_ctrl_multi_pkg;

  localparam int STALL_BUS = 6;

  typedef enum logic [1:0] {
    PC_IDLE  = 2'd0,
    PC_PEND  = 2'd1,
    PC_FLUSH = 2'd2
  } pc_state_e;

  // Counter width able to hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pip_stall_encoder.sv
// Highest-set-bit encoder: stall mask for the requester and all older
// stages, plus a one-hot bubble just above the youngest requester.
module pip_stall_encoder
  import pip_ctrl_multi_pkg::*;
#(
  parameter int NUM_STAGES = STALL_BUS
) (
  input  logic [NUM_STAGES-1:0] stallreq_stage,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] bubble
);

  // Stage k stalls if any stage at or above k asks; bubble sits at h+1.
  always_comb begin
    stall  = '0;
    bubble = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      stall[i] = |(stallreq_stage >> i);
    end
    for (int i = 1; i < NUM_STAGES; i++) begin
      bubble[i] = stallreq_stage[i-1] & ~(|(stallreq_stage >> i));
    end
  end

endmodule

// File: rtl/pip_ctrl_multi.sv
// Pipeline stall/flush controller: FSM, flush counter, stall merge.
// Optional global-stall watchdog enabled by defining STALL_WDT_EN.
module pip_ctrl_multi
  import pip_ctrl_multi_pkg::*;
#(
  parameter int NUM_STAGES   = STALL_BUS,
  parameter int FLUSH_CYCLES = 1,
  parameter int WDT_LIMIT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  except_en,
  input  logic [NUM_STAGES-1:0] stallreq_stage,
  input  logic                  stallreq_global,
  output logic                  flush,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] bubble,
  output logic                  flush_busy,
  output logic                  wdt_timeout
);

  localparam int CW = cnt_width(FLUSH_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(FLUSH_CYCLES - 1);

  pc_state_e             state;
  logic [CW-1:0]         cnt;
  logic [NUM_STAGES-1:0] enc_stall;
  logic [NUM_STAGES-1:0] enc_bubble;
  logic                  idle_exc;
  logic                  flush_req;

  pip_stall_encoder #(
    .NUM_STAGES(NUM_STAGES)
  ) u_enc (
    .stallreq_stage(stallreq_stage),
    .stall         (enc_stall),
    .bubble        (enc_bubble)
  );

  assign idle_exc  = (state == PC_IDLE) & except_en;
  assign flush_req = (state != PC_IDLE) | idle_exc;

  // Output merge: reset > global stall > flush > stage stalls.
  always_comb begin
    flush      = 1'b0;
    stall      = '0;
    bubble     = '0;
    flush_busy = 1'b0;
    if (!reset) begin
      flush_busy = flush_req;
      if (stallreq_global) begin
        stall = '1;
      end else if (flush_req) begin
        flush = 1'b1;
      end else begin
        stall  = enc_stall;
        bubble = enc_bubble;
      end
    end
  end

  // Flush FSM: capture under global stall, count flush-high cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PC_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        PC_IDLE: begin
          if (except_en) begin
            if (stallreq_global) begin
              state <= PC_PEND;
            end else if (FLUSH_CYCLES > 1) begin
              state <= PC_FLUSH;
              cnt   <= CW'(1);
            end
          end
        end
        PC_PEND: begin
          if (!stallreq_global) begin
            if (FLUSH_CYCLES > 1) begin
              state <= PC_FLUSH;
              cnt   <= CW'(1);
            end else begin
              state <= PC_IDLE;
            end
          end
        end
        PC_FLUSH: begin
          if (!stallreq_global) begin
            if (cnt == LAST) begin
              state <= PC_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= PC_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef STALL_WDT_EN
  localparam int WW = cnt_width(WDT_LIMIT + 1);
  localparam logic [WW-1:0] WLIM = WW'(WDT_LIMIT);

  logic [WW-1:0] wdt_cnt;

  // Saturating run-length of global stall; sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_cnt     <= '0;
      wdt_timeout <= 1'b0;
    end else if (stallreq_global) begin
      if (wdt_cnt != WLIM) wdt_cnt <= wdt_cnt + WW'(1);
      if (wdt_cnt == WLIM - WW'(1)) wdt_timeout <= 1'b1;
    end else begin
      wdt_cnt <= '0;
    end
  end
`else
  assign wdt_timeout = 1'b0;
`endif

endmodule
